// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: frame width default, receiver
// state encoding and packet-type codes carried in data_out[2:0].
package serial_pkg;

    localparam int FRAME_BITS_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam logic [2:0] DTYPE_PSTATE = 3'b000;
    localparam logic [2:0] DTYPE_OTHER  = 3'b001;
    localparam logic [2:0] DTYPE_ACK    = 3'b111;

endpackage

// File: rtl/serial_bit_timer.sv
// Restartable bit-period timer. While restart is high the counter is held
// at zero; once released, tick pulses for one cycle after the first period
// (CYCLES_PER_BIT/2 when half was high at restart, else CYCLES_PER_BIT) and
// then every CYCLES_PER_BIT cycles. tick is registered, so it is raised one
// cycle early to land exactly on the intended sample edge.
module serial_bit_timer #(
    parameter int CYCLES_PER_BIT = 564
) (
    input  logic clk,
    input  logic rst_in,
    input  logic restart,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] HALF_PRE  = CW'(CYCLES_PER_BIT / 2 - 2);
    localparam logic [CW-1:0] FULL_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_PRE  = CW'(CYCLES_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          half_r;
    logic          tick_r;
    logic [CW-1:0] last_s;
    logic [CW-1:0] pre_s;

    // Select wrap and pre-tick values for the current period length
    always_comb begin
        last_s = FULL_LAST;
        pre_s  = FULL_PRE;
        if (half_r) begin
            last_s = HALF_LAST;
            pre_s  = HALF_PRE;
        end else begin
            last_s = FULL_LAST;
            pre_s  = FULL_PRE;
        end
    end

    // Cycle counter, period-mode flag and registered sample tick
    always_ff @(posedge clk) begin
        if (rst_in || restart) begin
            cnt_r  <= '0;
            half_r <= half;
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == pre_s);
            if (cnt_r == last_s) begin
                cnt_r  <= '0;
                half_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
            end
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/serial_frame_rx.sv
// UART-style 32-bit frame receiver feeding the comms block.
// Frame: start(0), FRAME_BITS data bits LSB first, [even parity], stop(1).
// Optional feature: define SERIAL_RX_PARITY_EN to expect and check an even
// parity bit between the last data bit and the stop bit.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 564,
    parameter int FRAME_BITS     = FRAME_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  line_in,
    output logic                  valid,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  busy,
    output logic                  framing_err,
    output logic                  parity_err
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

    rx_state_t             state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic [FRAME_BITS-1:0] data_out_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  ferr_r;
    logic                  tick_s;
    logic                  restart_s;

`ifdef SERIAL_RX_PARITY_EN
    logic                  perr_r;
    logic                  par_bit_r;

    // Even parity: the transmitted bit equals the XOR of all data bits
    function automatic logic even_parity(input logic [FRAME_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // The timer is parked at zero whenever no frame is being timed
    assign restart_s = (state_r == ST_IDLE) || (state_r == ST_BREAK);

    serial_bit_timer #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst_in  (rst_in),
        .restart (restart_s),
        .half    (1'b1),
        .tick    (tick_s)
    );

    // Receiver FSM: state, shift register, bit count and registered strobes
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            ferr_r     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_r     <= 1'b0;
            par_bit_r  <= 1'b0;
`endif
        end else begin
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_r  <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (!line_in) begin
                        state_r   <= ST_START;
                        busy_r    <= 1'b1;
                        bit_cnt_r <= '0;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_START: begin
                    // A line that is high again mid start bit was a glitch
                    if (tick_s) begin
                        if (line_in) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Right shift: the first (LSB) bit ends up in bit 0
                    if (tick_s) begin
                        shift_r <= {line_in, shift_r[FRAME_BITS-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        par_bit_r <= line_in;
                        state_r   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // Return to IDLE at once so a back-to-back start is seen
                    if (tick_s) begin
                        if (line_in) begin
`ifdef SERIAL_RX_PARITY_EN
                            if (par_bit_r != even_parity(shift_r)) begin
                                perr_r <= 1'b1;
                            end else begin
                                valid_r    <= 1'b1;
                                data_out_r <= shift_r;
                            end
`else
                            valid_r    <= 1'b1;
                            data_out_r <= shift_r;
`endif
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            ferr_r  <= 1'b1;
                            state_r <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Held-low line: wait for idle before hunting a new start
                    if (line_in) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign valid       = valid_r;
    assign data_out    = data_out_r;
    assign busy        = busy_r;
    assign framing_err = ferr_r;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err  = perr_r;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx at CYCLES_PER_BIT=8. Frames are driven
// bit by bit on the falling edge; a monitor counts strobes just after each
// rising edge and stamps them with the rising-edge count.
module tb_serial_frame_rx;
    import serial_pkg::*;

    localparam int CPB = 8;
    localparam int FB  = 32;
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT       = CPB / 2 + (FB + 2) * CPB;
    localparam int FRAME_LEN = (FB + 3) * CPB;
`else
    localparam int LAT       = CPB / 2 + (FB + 1) * CPB;
    localparam int FRAME_LEN = (FB + 2) * CPB;
`endif

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          line_in = 1'b1;
    logic          valid;
    logic [FB-1:0] data_out;
    logic          busy;
    logic          framing_err;
    logic          parity_err;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int valid_cnt, ferr_cnt, perr_cnt;
    int first_valid_cyc, last_valid_cyc, ferr_cyc, perr_cyc, busy_fall_cyc;
    logic busy_prev = 1'b0;
    logic [FB-1:0] words[$];

    logic          snap_valid, snap_busy, snap_ferr, snap_perr;
    logic [FB-1:0] snap_data;

`ifdef SERIAL_RX_PARITY_EN
    logic tx_par_flip = 1'b0;
`endif

    serial_frame_rx #(
        .CYCLES_PER_BIT (CPB),
        .FRAME_BITS     (FB)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .line_in     (line_in),
        .valid       (valid),
        .data_out    (data_out),
        .busy        (busy),
        .framing_err (framing_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (valid === 1'b1) begin
            if (valid_cnt == 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
            valid_cnt = valid_cnt + 1;
            words.push_back(data_out);
        end
        if (framing_err === 1'b1) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
        if (parity_err === 1'b1) begin
            perr_cnt = perr_cnt + 1;
            perr_cyc = cyc;
        end
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic clear_mon();
        valid_cnt = 0; ferr_cnt = 0; perr_cnt = 0;
        first_valid_cyc = -1; last_valid_cyc = -1;
        ferr_cyc = -1; perr_cyc = -1; busy_fall_cyc = -1;
        words.delete();
    endtask

    // Called on a falling edge; returns on the falling edge ending the stop bit.
    // t0 is the rising edge that first samples the start bit.
    task automatic send_frame(input logic [FB-1:0] d, input logic stop_bit,
                              input int rst_bit, output int t0);
        line_in = 1'b0;
        t0 = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < FB; i++) begin
            line_in = d[i];
            if (i == rst_bit) begin
                @(negedge clk);
                rst_in = 1'b1;
                @(negedge clk);
                rst_in = 1'b0;
                snap_valid = valid; snap_busy = busy; snap_data = data_out;
                snap_ferr = framing_err; snap_perr = parity_err;
                repeat (CPB - 2) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
`ifdef SERIAL_RX_PARITY_EN
        line_in = (^d) ^ tx_par_flip;
        repeat (CPB) @(negedge clk);
`endif
        line_in = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        line_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", data_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (framing_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", framing_err); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    endtask

    task automatic test_single();
        int t0;
        clear_mon();
        send_frame(32'hA5C3_0007, 1'b1, -1, t0);
        repeat (4) @(negedge clk);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL single_count: got %0d want 1", valid_cnt); end
        tests++; if (last_valid_cyc !== t0 + LAT) begin fails++; $display("FAIL single_latency: got %0d want %0d", last_valid_cyc, t0 + LAT); end
        tests++; if (data_out !== 32'hA5C3_0007) begin fails++; $display("FAIL single_data: got %h want a5c30007", data_out); end
        tests++; if (data_out[2:0] !== DTYPE_ACK) begin fails++; $display("FAIL single_type: got %b want %b", data_out[2:0], DTYPE_ACK); end
        tests++; if (busy_fall_cyc !== t0 + LAT) begin fails++; $display("FAIL single_busy_fall: got %0d want %0d", busy_fall_cyc, t0 + LAT); end
        tests++; if (ferr_cnt + perr_cnt !== 0) begin fails++; $display("FAIL single_errs: got %0d want 0", ferr_cnt + perr_cnt); end
    endtask

    task automatic test_back_to_back();
        int t0a, t0b;
        clear_mon();
        send_frame(32'h1234_5678, 1'b1, -1, t0a);
        send_frame(32'hFFFF_FFF8, 1'b1, -1, t0b);
        repeat (4) @(negedge clk);
        tests++; if (valid_cnt !== 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", valid_cnt); end
        tests++; if (last_valid_cyc - first_valid_cyc !== FRAME_LEN) begin fails++; $display("FAIL b2b_spacing: got %0d want %0d", last_valid_cyc - first_valid_cyc, FRAME_LEN); end
        tests++;
        if (words.size() != 2) begin
            fails++; $display("FAIL b2b_words: got %0d words want 2", words.size());
        end else if (words[0] !== 32'h1234_5678 || words[1] !== 32'hFFFF_FFF8) begin
            fails++; $display("FAIL b2b_words: got %h %h want 12345678 fffffff8", words[0], words[1]);
        end
        tests++; if (last_valid_cyc !== t0b + LAT) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", last_valid_cyc, t0b + LAT); end
    endtask

    task automatic test_glitch();
        int t0;
        clear_mon();
        line_in = 1'b0;
        t0 = cyc + 1;
        repeat (3) @(negedge clk);
        line_in = 1'b1;
        repeat (12) @(negedge clk);
        tests++; if (busy_fall_cyc !== t0 + CPB / 2) begin fails++; $display("FAIL glitch_busy_fall: got %0d want %0d", busy_fall_cyc, t0 + CPB / 2); end
        tests++; if (valid_cnt + ferr_cnt + perr_cnt !== 0) begin fails++; $display("FAIL glitch_strobes: got %0d want 0", valid_cnt + ferr_cnt + perr_cnt); end
        tests++; if (data_out !== 32'hFFFF_FFF8) begin fails++; $display("FAIL glitch_data: got %h want fffffff8", data_out); end
    endtask

    task automatic test_framing();
        int t0, r;
        clear_mon();
        send_frame(32'h0000_0001, 1'b0, -1, t0);
        repeat (50 - CPB) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL break_busy: got %b want 1", busy); end
        line_in = 1'b1;
        r = cyc + 1;
        repeat (4) @(negedge clk);
        tests++; if (ferr_cnt !== 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
        tests++; if (ferr_cyc !== t0 + LAT) begin fails++; $display("FAIL ferr_time: got %0d want %0d", ferr_cyc, t0 + LAT); end
        tests++; if (valid_cnt + perr_cnt !== 0) begin fails++; $display("FAIL ferr_other: got %0d want 0", valid_cnt + perr_cnt); end
        tests++; if (busy_fall_cyc !== r) begin fails++; $display("FAIL break_exit: got %0d want %0d", busy_fall_cyc, r); end
        tests++; if (data_out !== 32'hFFFF_FFF8) begin fails++; $display("FAIL ferr_data: got %h want fffffff8", data_out); end
    endtask

    task automatic test_reset_mid();
        int t0a, t0b;
        clear_mon();
        send_frame(32'hFFFF_FC00, 1'b1, 10, t0a);
        tests++; if (snap_data !== 32'h0) begin fails++; $display("FAIL midrst_data: got %h want 0", snap_data); end
        tests++; if ({snap_valid, snap_busy, snap_ferr, snap_perr} !== 4'b0000) begin fails++; $display("FAIL midrst_flags: got %b want 0000", {snap_valid, snap_busy, snap_ferr, snap_perr}); end
        send_frame(32'h0F0F_1230, 1'b1, -1, t0b);
        repeat (4) @(negedge clk);
        tests++; if (valid_cnt !== 1) begin fails++; $display("FAIL midrst_count: got %0d want 1", valid_cnt); end
        tests++; if (last_valid_cyc !== t0b + LAT) begin fails++; $display("FAIL midrst_latency: got %0d want %0d", last_valid_cyc, t0b + LAT); end
        tests++; if (data_out !== 32'h0F0F_1230) begin fails++; $display("FAIL midrst_next: got %h want 0f0f1230", data_out); end
        tests++; if (data_out[2:0] !== DTYPE_PSTATE) begin fails++; $display("FAIL midrst_type: got %b want %b", data_out[2:0], DTYPE_PSTATE); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        int t0;
        clear_mon();
        tx_par_flip = 1'b1;
        send_frame(32'h0000_0003, 1'b1, -1, t0);
        tx_par_flip = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (perr_cnt !== 1) begin fails++; $display("FAIL perr_count: got %0d want 1", perr_cnt); end
        tests++; if (perr_cyc !== t0 + LAT) begin fails++; $display("FAIL perr_time: got %0d want %0d", perr_cyc, t0 + LAT); end
        tests++; if (valid_cnt + ferr_cnt !== 0) begin fails++; $display("FAIL perr_other: got %0d want 0", valid_cnt + ferr_cnt); end
        tests++; if (data_out !== 32'h0F0F_1230) begin fails++; $display("FAIL perr_data: got %h want 0f0f1230", data_out); end
        clear_mon();
        send_frame(32'h0000_0003, 1'b1, -1, t0);
        repeat (4) @(negedge clk);
        tests++; if (valid_cnt !== 1 || perr_cnt !== 0) begin fails++; $display("FAIL par_good: got valid %0d perr %0d want 1 0", valid_cnt, perr_cnt); end
        tests++; if (data_out !== 32'h0000_0003) begin fails++; $display("FAIL par_good_data: got %h want 00000003", data_out); end
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
